vrf_write_arbiter: RTL and testbench

//  Shares the single vector-register-file write port (write_addr/write_vector/we)

---
 rtl/vrf_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/vrf_write_arbiter.sv | 120 ++++++++++++
 tb/tb_vrf_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared sizes and types for the VRF write-port arbiter.
package vrf_pkg;

  localparam int NUM_LANES  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int VEC_WIDTH  = NUM_LANES * DATA_WIDTH;

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } vwa_state_e;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant cell: requester A is the ALU, requester B is the LSU.
// After a granted transfer the priority passes to the source that lost; force_a hands it to A.
import vrf_pkg::*;

module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  input  logic force_a,
  output logic gnt_a,
  output logic gnt_b
);

  prio_e prio_q, prio_d;

  always_comb begin
    gnt_a  = en & req_a & (~req_b | (prio_q == PRIO_ALU));
    gnt_b  = en & req_b & (~req_a | (prio_q == PRIO_LSU));
    prio_d = prio_q;
    if (force_a) begin
      prio_d = PRIO_ALU;
    end else if (upd) begin
      prio_d = gnt_a ? PRIO_LSU : PRIO_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      prio_q <= PRIO_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Shares the VRF write port between the vector ALU and vector LSU writeback paths.
// Note that rst_n is a synchronous, active-high reset despite its name.
//
//  state | meaning
//  IDLE  | round-robin arbitration between ALU and LSU
//  LOCK  | LSU burst owns the port until lsu_last or MAX_BURST beats
import vrf_pkg::*;

module vrf_write_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [VEC_WIDTH-1:0]  alu_data,
  input  logic [NUM_LANES-1:0]  alu_mask,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [VEC_WIDTH-1:0]  lsu_data,
  input  logic [NUM_LANES-1:0]  lsu_mask,
  input  logic                  lsu_last,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [VEC_WIDTH-1:0]  write_vector,
  output logic [NUM_LANES-1:0]  we,
  output logic                  locked
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  vwa_state_e            state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  vec_t                  write_vector_q, write_vector_d;
  logic [NUM_LANES-1:0]  we_q, we_d;

  logic arb_en, arb_upd, gnt_alu, gnt_lsu;
  logic alu_xfer, lsu_xfer, lock_end;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .req_a   (alu_valid),
    .req_b   (lsu_valid),
    .upd     (arb_upd),
    .force_a (lock_end),
    .gnt_a   (gnt_alu),
    .gnt_b   (gnt_lsu)
  );

  always_comb begin
    arb_en    = ~rst_n & ~flush & (state_q == IDLE);
    arb_upd   = gnt_alu | gnt_lsu;
    alu_ready = gnt_alu;
    lsu_ready = (state_q == LOCK) ? (lsu_valid & ~rst_n & ~flush) : gnt_lsu;
    alu_xfer  = alu_valid & alu_ready;
    lsu_xfer  = lsu_valid & lsu_ready;
    // A lock ends on the marked last beat or when this beat would be the MAX_BURST-th.
    lock_end  = (state_q == LOCK) & lsu_xfer & (lsu_last | (beat_cnt_q == CNT_LAST));

    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    write_addr_d   = write_addr_q;
    write_vector_d = write_vector_q;
    we_d           = '0;

    if (alu_xfer) begin
      write_addr_d   = alu_addr;
      write_vector_d = alu_data;
      we_d           = alu_mask;
    end else if (lsu_xfer) begin
      write_addr_d   = lsu_addr;
      write_vector_d = lsu_data;
      we_d           = lsu_mask;
    end

    if (flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (lsu_xfer && !lsu_last && (MAX_BURST > 1)) begin
        state_d    = LOCK;
        beat_cnt_d = CNT_ONE;
      end
    end else if (lock_end) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else if (lsu_xfer) begin
      beat_cnt_d = beat_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= IDLE;
      beat_cnt_q     <= '0;
      write_addr_q   <= '0;
      write_vector_q <= '0;
      we_q           <= '0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      write_addr_q   <= write_addr_d;
      write_vector_q <= write_vector_d;
      we_q           <= we_d;
    end
  end

  assign write_addr   = write_addr_q;
  assign write_vector = write_vector_q;
  assign we           = we_q;
  assign locked       = (state_q == LOCK);

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Scoreboard bench for vrf_write_arbiter: directed scenarios followed by random traffic.
module tb_vrf_write_arbiter;
  import vrf_pkg::*;

  localparam int MAX_BURST = 4;
  localparam int VW = NUM_LANES * DATA_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, flush, alu_valid, alu_ready, lsu_valid, lsu_ready, lsu_last, locked;
  logic [ADDR_WIDTH-1:0] alu_addr, lsu_addr, write_addr;
  logic [VW-1:0]         alu_data, lsu_data, write_vector;
  logic [NUM_LANES-1:0]  alu_mask, lsu_mask, we;

  vrf_write_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_mask(alu_mask),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
    .lsu_data(lsu_data), .lsu_mask(lsu_mask), .lsu_last(lsu_last),
    .write_addr(write_addr), .write_vector(write_vector), .we(we), .locked(locked)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [VW-1:0]         data;
    logic [NUM_LANES-1:0]  mask;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_chk = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  // Reference model: who owns the port, how many beats the current burst has used,
  // whose turn it is, and the last accepted address/data.
  bit                    m_lock;
  int                    m_beats;
  bit                    m_prio_lsu;
  logic [ADDR_WIDTH-1:0] m_wa;
  logic [VW-1:0]         m_wv;
  bit                    g_alu, g_lsu;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    bit ga, gl;
    #1;
    ga = 1'b0;
    gl = 1'b0;
    if (!rst_n && !flush) begin
      if (m_lock) gl = lsu_valid;
      else if (alu_valid && (!lsu_valid || !m_prio_lsu)) ga = 1'b1;
      else if (lsu_valid) gl = 1'b1;
    end
    chk("alu_ready", alu_ready, ga);
    chk("lsu_ready", lsu_ready, gl);
    chk("locked", locked, m_lock);
    g_alu = alu_ready;
    g_lsu = lsu_ready;

    if (rst_n) begin
      m_lock = 0; m_beats = 0; m_prio_lsu = 0; m_wa = '0; m_wv = '0;
    end else if (flush) begin
      m_lock = 0; m_beats = 0;
    end else if (ga) begin
      if (alu_mask != '0) exp_q.push_back('{alu_addr, alu_data, alu_mask});
      m_wa = alu_addr; m_wv = alu_data; m_prio_lsu = 1;
    end else if (gl) begin
      if (lsu_mask != '0) exp_q.push_back('{lsu_addr, lsu_data, lsu_mask});
      m_wa = lsu_addr; m_wv = lsu_data;
      if (m_lock) begin
        m_beats++;
        if (lsu_last || m_beats == MAX_BURST) begin
          m_lock = 0; m_beats = 0; m_prio_lsu = 0;
        end
      end else begin
        m_prio_lsu = 0;
        if (!lsu_last && MAX_BURST > 1) begin
          m_lock = 1; m_beats = 1;
        end
      end
    end

    @(posedge clk);
    #1;
    chk("hold_addr", write_addr, m_wa);
    chk("hold_vector", write_vector, m_wv);
  endtask

  task automatic idle_inputs();
    rst_n = 0; flush = 0; alu_valid = 0; lsu_valid = 0; lsu_last = 0;
    alu_mask = 4'hF; lsu_mask = 4'hF;
    alu_addr = 5'($urandom); lsu_addr = 5'($urandom);
    alu_data = rnd_vec(); lsu_data = rnd_vec();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1;
    step();
    rst_n = 0;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && we !== '0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL spurious_write: got we=%0h addr=%0h expected no write", we, write_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_we", we, mon_e.mask);
          chk("mon_addr", write_addr, mon_e.addr);
          chk("mon_vector", write_vector, mon_e.data);
        end
      end
    end
  end

  initial begin
    logic [3:0] pat4;
    logic [6:0] pat7;
    int beats;

    idle_inputs();
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    m_lock = 0; m_beats = 0; m_prio_lsu = 0; m_wa = '0; m_wv = '0;
    mon_en = 1;
    step();
    chk("rst_we", we, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_vector", write_vector, 0);
    chk("rst_locked", locked, 0);
    rst_n = 0;

    // Single ALU write, one-cycle latency to the VRF port
    alu_valid = 1; alu_addr = 5'd3; alu_mask = 4'hF;
    alu_data = {32'd1, 32'd2, 32'd3, 32'd4};
    step();
    chk("t1_alu_ready", g_alu, 1);
    chk("t1_we", we, 4'hF);
    chk("t1_addr", write_addr, 3);
    chk("t1_vector", write_vector, {32'd1, 32'd2, 32'd3, 32'd4});
    alu_valid = 0;
    step();
    chk("t1_we_drop", we, 0);

    // Both sources always valid with single-beat LSU writes: strict alternation
    do_reset();
    alu_valid = 1; lsu_valid = 1; lsu_last = 1;
    pat4 = '0;
    for (int i = 0; i < 4; i++) begin
      alu_addr = 5'($urandom); lsu_addr = 5'($urandom);
      alu_data = rnd_vec(); lsu_data = rnd_vec();
      step();
      chk("t2_one_ready", 2'(g_alu) + 2'(g_lsu), 1);
      pat4 = {pat4[2:0], g_alu};
    end
    chk("t2_pattern", pat4, 4'b1010);

    // Three-beat burst holds off a waiting ALU
    do_reset();
    lsu_valid = 1; lsu_last = 0;
    step();
    chk("t3_locked_b1", locked, 1);
    alu_valid = 1; lsu_data = rnd_vec();
    step();
    chk("t3_alu_blocked", g_alu, 0);
    chk("t3_locked_b2", locked, 1);
    lsu_last = 1; lsu_data = rnd_vec();
    step();
    chk("t3_lsu_b3", g_lsu, 1);
    chk("t3_unlocked", locked, 0);
    lsu_valid = 0; lsu_last = 0;
    step();
    chk("t3_alu_after", g_alu, 1);
    alu_valid = 0;

    // Six beats without lsu_last: forced release after four, ALU slips in
    do_reset();
    lsu_valid = 1; lsu_last = 0;
    beats = 0;
    pat7 = '0;
    for (int c = 0; c < 20 && beats < 6; c++) begin
      step();
      if (g_lsu) beats++;
      if (g_alu || g_lsu) pat7 = {pat7[5:0], g_alu};
      alu_valid = 1;
      alu_data = rnd_vec(); lsu_data = rnd_vec();
      lsu_addr = 5'($urandom);
    end
    chk("t4_beats", beats, 6);
    chk("t4_pattern", pat7, 7'b0000100);
    lsu_valid = 0;
    step();

    // Gap inside a burst, then flush
    do_reset();
    lsu_valid = 1; lsu_last = 0;
    step();
    lsu_data = rnd_vec();
    step();
    lsu_valid = 0; alu_valid = 1;
    step();
    chk("t5_gap1_we", we, 0);
    chk("t5_gap1_locked", locked, 1);
    step();
    chk("t5_gap2_we", we, 0);
    chk("t5_gap2_alu", g_alu, 0);
    flush = 1;
    step();
    chk("t5_flush_alu", g_alu, 0);
    chk("t5_flush_unlocked", locked, 0);
    chk("t5_flush_we", we, 0);
    flush = 0;
    step();
    chk("t5_alu_after_flush", g_alu, 1);
    alu_valid = 0;

    // Reset while locked with both requesters valid
    do_reset();
    lsu_valid = 1; lsu_last = 0;
    step();
    alu_valid = 1; rst_n = 1;
    step();
    chk("t6_we", we, 0);
    chk("t6_locked", locked, 0);
    step();
    chk("t6_alu_ready_held", g_alu, 0);
    chk("t6_lsu_ready_held", g_lsu, 0);
    rst_n = 0;

    // Random traffic against the model
    idle_inputs();
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 99) < 1);
      flush     = ($urandom_range(0, 99) < 5);
      alu_valid = ($urandom_range(0, 9) < 6);
      lsu_valid = ($urandom_range(0, 9) < 6);
      lsu_last  = ($urandom_range(0, 9) < 3);
      alu_addr  = 5'($urandom);
      lsu_addr  = 5'($urandom);
      alu_data  = rnd_vec();
      lsu_data  = rnd_vec();
      alu_mask  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      lsu_mask  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      step();
    end

    idle_inputs();
    step();
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
